// File: rtl/mem_bus_pkg.sv
// Shared constants for the two-master memory bus arbiter: state encoding,
// master indices and the default read data returned on a timed-out access.
package mem_bus_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    localparam logic MST_CPU = 1'b0;
    localparam logic MST_AUX = 1'b1;

    localparam logic [31:0] ERROR_RDATA_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/bus_watchdog.sv
// Transaction watchdog: counts stalled BUSY cycles and flags the cycle in which
// the count reaches TIMEOUT-1, i.e. the TIMEOUT-th cycle without a handshake.
module bus_watchdog #(
    parameter int TIMEOUT_BITS = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic clk,
    input  logic nreset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TIMEOUT_BITS-1:0] LAST = TIMEOUT_BITS'(TIMEOUT - 1);

    logic [TIMEOUT_BITS-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + TIMEOUT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory/peripheral bus between the CPU (master 0)
// and an auxiliary requester (master 1); one grant per transaction, watchdog-bounded.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    TIMEOUT_BITS = 8,
    parameter int                    TIMEOUT      = 255,
    parameter logic [DATA_WIDTH-1:0] ERROR_RDATA  = ERROR_RDATA_DEFAULT
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  m0_valid,
    input  logic                  m0_nwr,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_ready,
    output logic                  m0_error,
    input  logic                  m1_valid,
    input  logic                  m1_nwr,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_ready,
    output logic                  m1_error,
    output logic                  s_valid,
    output logic                  s_nwr,
    output logic [ADDR_WIDTH-1:0] s_address,
    output logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic                  s_ready,
    output logic                  grant,
    output logic                  busy,
    output logic                  bus_error,
    input  logic                  error_clear
);

    logic state_q, state_d;
    logic grant_q, grant_d;
    logic last_grant_q, last_grant_d;
    logic bus_error_q, bus_error_d;

    logic                  gnt_valid;
    logic                  complete;
    logic                  timeout;
    logic                  done;
    logic                  wd_expired;
    logic [DATA_WIDTH-1:0] rsp_data;

    assign busy      = (state_q == ST_BUSY);
    assign grant     = grant_q;
    assign bus_error = bus_error_q;

    // Slave side follows the grant register even in IDLE; only s_valid is gated.
    assign gnt_valid = (grant_q == MST_AUX) ? m1_valid   : m0_valid;
    assign s_nwr     = (grant_q == MST_AUX) ? m1_nwr     : m0_nwr;
    assign s_address = (grant_q == MST_AUX) ? m1_address : m0_address;
    assign s_wdata   = (grant_q == MST_AUX) ? m1_wdata   : m0_wdata;
    assign s_valid   = busy & gnt_valid;

    assign complete = s_valid & s_ready;
    assign timeout  = s_valid & ~s_ready & wd_expired;
    assign done     = complete | timeout;
    assign rsp_data = timeout ? ERROR_RDATA : s_rdata;

    assign m0_ready = done & (grant_q == MST_CPU);
    assign m1_ready = done & (grant_q == MST_AUX);
    assign m0_error = timeout & (grant_q == MST_CPU);
    assign m1_error = timeout & (grant_q == MST_AUX);
    assign m0_rdata = m0_ready ? rsp_data : '0;
    assign m1_rdata = m1_ready ? rsp_data : '0;

    bus_watchdog #(
        .TIMEOUT_BITS (TIMEOUT_BITS),
        .TIMEOUT      (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .nreset  (nreset),
        .clr     (~busy),
        .en      (s_valid & ~done),
        .expired (wd_expired)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        bus_error_d  = bus_error_q;

        if (state_q == ST_IDLE) begin
            if (m0_valid | m1_valid) begin
                // Under contention the previous owner yields; last_grant resets to 1 so the CPU wins first.
                grant_d = (m0_valid & m1_valid) ? ~last_grant_q : m1_valid;
                state_d = ST_BUSY;
            end
        end else begin
            if (done) begin
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end else if (!gnt_valid) begin
                state_d = ST_IDLE;
            end
        end

        if (timeout) begin
            bus_error_d = 1'b1;
        end else if (error_clear) begin
            bus_error_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= ST_IDLE;
            grant_q      <= MST_CPU;
            last_grant_q <= MST_AUX;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            bus_error_q  <= bus_error_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table, hand-written reset/abort sequences and
// a randomized run against a transaction-level reference model (TIMEOUT = 4).
module tb_mem_bus_arbiter;

    localparam int TMO = 4;
    localparam logic [31:0] A0 = 32'h2000_0004;
    localparam logic [31:0] A1 = 32'h7FFF_FFF0;

    logic        clk = 1'b0;
    logic        nreset;
    logic        m0_valid, m0_nwr, m1_valid, m1_nwr;
    logic [31:0] m0_address, m0_wdata, m1_address, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m0_error, m1_ready, m1_error;
    logic        s_valid, s_nwr, s_ready;
    logic [31:0] s_address, s_wdata, s_rdata;
    logic        grant, busy, bus_error, error_clear;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .TIMEOUT_BITS (3),
        .TIMEOUT      (TMO),
        .ERROR_RDATA  (32'hFFFF_FFFF)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .m0_valid    (m0_valid),
        .m0_nwr      (m0_nwr),
        .m0_address  (m0_address),
        .m0_wdata    (m0_wdata),
        .m0_rdata    (m0_rdata),
        .m0_ready    (m0_ready),
        .m0_error    (m0_error),
        .m1_valid    (m1_valid),
        .m1_nwr      (m1_nwr),
        .m1_address  (m1_address),
        .m1_wdata    (m1_wdata),
        .m1_rdata    (m1_rdata),
        .m1_ready    (m1_ready),
        .m1_error    (m1_error),
        .s_valid     (s_valid),
        .s_nwr       (s_nwr),
        .s_address   (s_address),
        .s_wdata     (s_wdata),
        .s_rdata     (s_rdata),
        .s_ready     (s_ready),
        .grant       (grant),
        .busy        (busy),
        .bus_error   (bus_error),
        .error_clear (error_clear)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    typedef struct {
        logic        m0v, m1v, sr, eclr;
        logic [31:0] srd;
        logic        sv, gnt, bsy, berr, r0, r1, e0, e1;
        logic [31:0] rd;
    } vec_t;

    function automatic vec_t v(logic m0v, logic m1v, logic sr, logic eclr, logic [31:0] srd,
                               logic sv, logic gnt, logic bsy, logic berr,
                               logic r0, logic r1, logic e0, logic e1, logic [31:0] rd);
        vec_t x;
        x.m0v = m0v; x.m1v = m1v; x.sr = sr; x.eclr = eclr; x.srd = srd;
        x.sv = sv; x.gnt = gnt; x.bsy = bsy; x.berr = berr;
        x.r0 = r0; x.r1 = r1; x.e0 = e0; x.e1 = e1; x.rd = rd;
        return x;
    endfunction

    // Model state: owner, previous completed owner, busy flag, stalled-cycle age, sticky error.
    int own, last, age;
    bit mbusy, merr;

    task automatic model_reset();
        own = 0; last = 1; age = 0; mbusy = 0; merr = 0;
    endtask

    task automatic model_check_and_step(input string tag);
        bit gv, sv, comp, to;
        logic [31:0] rd, ea, ew;
        logic en;
        gv   = own ? m1_valid : m0_valid;
        sv   = mbusy && gv;
        comp = sv && s_ready;
        to   = sv && !s_ready && (age == TMO - 1);
        rd   = to ? 32'hFFFF_FFFF : s_rdata;
        ea   = own ? m1_address : m0_address;
        ew   = own ? m1_wdata : m0_wdata;
        en   = own ? m1_nwr : m0_nwr;
        chk({tag, ".ctl"}, {60'd0, s_valid, grant, busy, bus_error},
            {60'd0, sv, own[0], mbusy, merr});
        chk({tag, ".rsp"}, {60'd0, m0_ready, m1_ready, m0_error, m1_error},
            {60'd0, (comp || to) && own == 0, (comp || to) && own == 1, to && own == 0, to && own == 1});
        chk({tag, ".rdata"}, {m0_rdata, m1_rdata},
            {((comp || to) && own == 0) ? rd : 32'd0, ((comp || to) && own == 1) ? rd : 32'd0});
        chk({tag, ".addr"}, {31'd0, s_nwr, s_address}, {31'd0, en, ea});
        chk({tag, ".wdata"}, {32'd0, s_wdata}, {32'd0, ew});
        if (!mbusy) begin
            if (m0_valid || m1_valid) begin
                own   = (m0_valid && m1_valid) ? 1 - last : (m1_valid ? 1 : 0);
                mbusy = 1;
                age   = 0;
            end
        end else if (comp || to) begin
            last  = own;
            mbusy = 0;
        end else if (!gv) begin
            mbusy = 0;
        end else begin
            age++;
        end
        if (to) merr = 1;
        else if (error_clear) merr = 0;
    endtask

    vec_t tbl[24];

    initial begin
        tbl[0]  = v(1,0,0,0,32'h0,        0,0,0,0, 0,0,0,0, 32'h0);
        tbl[1]  = v(1,0,1,0,32'hDEADBEEF, 1,0,1,0, 1,0,0,0, 32'hDEADBEEF);
        tbl[2]  = v(0,0,0,0,32'h0,        0,0,0,0, 0,0,0,0, 32'h0);
        tbl[3]  = v(1,1,1,0,32'h11111111, 0,0,0,0, 0,0,0,0, 32'h0);
        tbl[4]  = v(1,1,1,0,32'h22222222, 1,1,1,0, 0,1,0,0, 32'h22222222);
        tbl[5]  = v(1,1,1,0,32'h33333333, 0,1,0,0, 0,0,0,0, 32'h0);
        tbl[6]  = v(1,1,1,0,32'h44444444, 1,0,1,0, 1,0,0,0, 32'h44444444);
        tbl[7]  = v(1,1,1,0,32'h55555555, 0,0,0,0, 0,0,0,0, 32'h0);
        tbl[8]  = v(1,1,1,0,32'h66666666, 1,1,1,0, 0,1,0,0, 32'h66666666);
        tbl[9]  = v(0,0,0,0,32'h0,        0,1,0,0, 0,0,0,0, 32'h0);
        tbl[10] = v(0,1,0,0,32'h0,        0,1,0,0, 0,0,0,0, 32'h0);
        tbl[11] = v(0,1,0,0,32'hAAAA0000, 1,1,1,0, 0,0,0,0, 32'h0);
        tbl[12] = v(0,1,0,0,32'hAAAA0001, 1,1,1,0, 0,0,0,0, 32'h0);
        tbl[13] = v(0,1,0,0,32'hAAAA0002, 1,1,1,0, 0,0,0,0, 32'h0);
        tbl[14] = v(0,1,0,0,32'hAAAA0003, 1,1,1,0, 0,1,0,1, 32'hFFFFFFFF);
        tbl[15] = v(0,0,0,0,32'h0,        0,1,0,1, 0,0,0,0, 32'h0);
        tbl[16] = v(0,0,0,1,32'h0,        0,1,0,1, 0,0,0,0, 32'h0);
        tbl[17] = v(0,0,0,0,32'h0,        0,1,0,0, 0,0,0,0, 32'h0);
        tbl[18] = v(1,0,0,0,32'h0,        0,1,0,0, 0,0,0,0, 32'h0);
        tbl[19] = v(1,0,0,0,32'h0,        1,0,1,0, 0,0,0,0, 32'h0);
        tbl[20] = v(1,0,0,0,32'h0,        1,0,1,0, 0,0,0,0, 32'h0);
        tbl[21] = v(1,0,0,0,32'h0,        1,0,1,0, 0,0,0,0, 32'h0);
        tbl[22] = v(1,0,1,0,32'h12345678, 1,0,1,0, 1,0,0,0, 32'h12345678);
        tbl[23] = v(0,0,0,0,32'h0,        0,0,0,0, 0,0,0,0, 32'h0);

        nreset = 1'b0;
        m0_valid = 0; m1_valid = 0; s_ready = 0; error_clear = 0;
        m0_nwr = 1'b1; m1_nwr = 1'b0;
        m0_address = A0; m1_address = A1;
        m0_wdata = 32'h0A0A0A0A; m1_wdata = 32'h1B1B1B1B; s_rdata = 32'h0;

        #12;
        chk("reset.ctl", {60'd0, s_valid, grant, busy, bus_error}, 64'd0);
        chk("reset.rsp", {60'd0, m0_ready, m1_ready, m0_error, m1_error}, 64'd0);
        chk("reset.slave_mux", {31'd0, s_nwr, s_address}, {31'd0, 1'b1, A0});
        #5 nreset = 1'b1;

        for (int i = 0; i < 24; i++) begin
            m0_valid = tbl[i].m0v; m1_valid = tbl[i].m1v;
            s_ready = tbl[i].sr; error_clear = tbl[i].eclr; s_rdata = tbl[i].srd;
            @(negedge clk);
            chk($sformatf("tbl%0d.ctl", i), {60'd0, s_valid, grant, busy, bus_error},
                {60'd0, tbl[i].sv, tbl[i].gnt, tbl[i].bsy, tbl[i].berr});
            chk($sformatf("tbl%0d.rsp", i), {60'd0, m0_ready, m1_ready, m0_error, m1_error},
                {60'd0, tbl[i].r0, tbl[i].r1, tbl[i].e0, tbl[i].e1});
            chk($sformatf("tbl%0d.rdata", i), {m0_rdata, m1_rdata},
                {tbl[i].r0 ? tbl[i].rd : 32'd0, tbl[i].r1 ? tbl[i].rd : 32'd0});
            chk($sformatf("tbl%0d.addr", i), {31'd0, s_nwr, s_address},
                {31'd0, ~tbl[i].gnt, tbl[i].gnt ? A1 : A0});
            @(posedge clk); #1;
        end

        // Asynchronous reset while master 1 owns the bus.
        m1_valid = 1'b1;
        @(posedge clk); #2;
        chk("rstbusy.pre", {62'd0, busy, grant}, {62'd0, 1'b1, 1'b1});
        nreset = 1'b0;
        #1;
        chk("rstbusy.ctl", {61'd0, s_valid, busy, grant}, 64'd0);
        chk("rstbusy.rsp", {62'd0, m1_ready, m1_error}, 64'd0);
        m1_valid = 1'b0;
        @(posedge clk); #1;
        nreset = 1'b1;

        // Abort: m0 owns the bus and drops valid while m1 keeps requesting.
        m0_valid = 1; m1_valid = 1; s_ready = 0;
        @(negedge clk);
        chk("abort.idle", {62'd0, busy, grant}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort.busy1", {60'd0, busy, grant, s_valid, m0_ready}, {60'd0, 4'b1010});
        @(posedge clk); #1;
        m0_valid = 0;
        @(negedge clk);
        chk("abort.drop", {61'd0, s_valid, m0_ready, m1_ready}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort.back_idle", {62'd0, busy, grant}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort.m1_grant", {61'd0, busy, grant, s_valid}, {61'd0, 3'b111});
        chk("abort.m1_addr", {32'd0, s_address}, {32'd0, A1});
        @(posedge clk); #1;

        // Randomized run against the reference model.
        m0_valid = 0; m1_valid = 0; s_ready = 0; error_clear = 0;
        nreset = 1'b0;
        #2 nreset = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            m0_valid    = ($urandom_range(3) != 0);
            m1_valid    = ($urandom_range(3) != 0);
            m0_nwr      = $urandom_range(1);
            m1_nwr      = $urandom_range(1);
            m0_address  = $urandom;
            m1_address  = $urandom;
            m0_wdata    = $urandom;
            m1_wdata    = $urandom;
            s_rdata     = $urandom;
            s_ready     = ($urandom_range(2) == 0);
            error_clear = ($urandom_range(7) == 0);
            @(negedge clk);
            model_check_and_step($sformatf("rnd%0d", c));
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
